// File: rtl/reservation_station_pkg.sv
// Shared widths and types for the ALU reservation station.
package reservation_station_pkg;

  localparam int unsigned RS_SIZE_WIDTH_DEF  = 3;
  localparam int unsigned ROB_SIZE_WIDTH_DEF = 4;
  localparam int unsigned OP_WIDTH           = 5;
  localparam int unsigned DATA_WIDTH         = 32;

  typedef logic [OP_WIDTH-1:0]   op_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/reservation_station_pick_lowest.sv
// Priority encoder: index of the lowest set bit of req, plus a found flag.
module rs_pick_lowest
  import reservation_station_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // First set bit wins; later hits are masked by found.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU/branch reservation station: dispatch, CDB wakeup, single issue per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE_WIDTH  = RS_SIZE_WIDTH_DEF,
  parameter int unsigned ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      disp_valid,
  input  logic [4:0]                disp_op,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_rob_id,
  input  logic                      disp_q1_rdy,
  input  logic [31:0]               disp_v1,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_q1,
  input  logic                      disp_q2_rdy,
  input  logic [31:0]               disp_v2,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_q2,
  input  logic                      alu_cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_cdb_rob_id,
  input  logic [31:0]               alu_cdb_value,
  input  logic                      lsb_cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_cdb_rob_id,
  input  logic [31:0]               lsb_cdb_value,
  output logic                      alu_valid,
  output logic [4:0]                alu_op,
  output logic [31:0]               alu_v1,
  output logic [31:0]               alu_v2,
  output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
  output logic                      rs_full
);

  localparam int unsigned RS_SIZE = 1 << RS_SIZE_WIDTH;

  typedef logic [ROB_SIZE_WIDTH-1:0] tag_t;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] r1_q, r1_d;
  logic [RS_SIZE-1:0] r2_q, r2_d;
  op_t                op_q  [RS_SIZE];
  op_t                op_d  [RS_SIZE];
  tag_t               rob_q [RS_SIZE];
  tag_t               rob_d [RS_SIZE];
  tag_t               q1_q  [RS_SIZE];
  tag_t               q1_d  [RS_SIZE];
  tag_t               q2_q  [RS_SIZE];
  tag_t               q2_d  [RS_SIZE];
  word_t              v1_q  [RS_SIZE];
  word_t              v1_d  [RS_SIZE];
  word_t              v2_q  [RS_SIZE];
  word_t              v2_d  [RS_SIZE];

  logic  alu_valid_q, alu_valid_d;
  op_t   alu_op_q, alu_op_d;
  word_t alu_v1_q, alu_v1_d;
  word_t alu_v2_q, alu_v2_d;
  tag_t  alu_rob_id_q, alu_rob_id_d;

  logic [RS_SIZE-1:0]       ready_vec;
  logic [RS_SIZE_WIDTH-1:0] free_idx, iss_idx;
  logic                     free_found, iss_found;

  assign ready_vec = busy_q & r1_q & r2_q;
  assign rs_full   = &busy_q;

  rs_pick_lowest #(.N(RS_SIZE), .IDX_W(RS_SIZE_WIDTH)) u_pick_free (
    .req   (~busy_q),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_pick_lowest #(.N(RS_SIZE), .IDX_W(RS_SIZE_WIDTH)) u_pick_issue (
    .req   (ready_vec),
    .idx   (iss_idx),
    .found (iss_found)
  );

  assign alu_valid  = alu_valid_q;
  assign alu_op     = alu_op_q;
  assign alu_v1     = alu_v1_q;
  assign alu_v2     = alu_v2_q;
  assign alu_rob_id = alu_rob_id_q;

  function automatic logic alu_hit(input tag_t t);
    return alu_cdb_valid && (alu_cdb_rob_id == t);
  endfunction

  function automatic logic lsb_hit(input tag_t t);
    return lsb_cdb_valid && (lsb_cdb_rob_id == t);
  endfunction

  // Next state: clear wins; otherwise wakeup, issue from pre-edge state, dispatch into a free slot.
  always_comb begin
    busy_d       = busy_q;
    r1_d         = r1_q;
    r2_d         = r2_q;
    op_d         = op_q;
    rob_d        = rob_q;
    q1_d         = q1_q;
    q2_d         = q2_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    alu_valid_d  = 1'b0;
    alu_op_d     = alu_op_q;
    alu_v1_d     = alu_v1_q;
    alu_v2_d     = alu_v2_q;
    alu_rob_id_d = alu_rob_id_q;

    if (clear) begin
      busy_d = '0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && !r1_q[i]) begin
          if (alu_hit(q1_q[i])) begin
            v1_d[i] = alu_cdb_value;
            r1_d[i] = 1'b1;
          end else if (lsb_hit(q1_q[i])) begin
            v1_d[i] = lsb_cdb_value;
            r1_d[i] = 1'b1;
          end
        end
        if (busy_q[i] && !r2_q[i]) begin
          if (alu_hit(q2_q[i])) begin
            v2_d[i] = alu_cdb_value;
            r2_d[i] = 1'b1;
          end else if (lsb_hit(q2_q[i])) begin
            v2_d[i] = lsb_cdb_value;
            r2_d[i] = 1'b1;
          end
        end
      end

      if (iss_found) begin
        alu_valid_d      = 1'b1;
        alu_op_d         = op_q[iss_idx];
        alu_v1_d         = v1_q[iss_idx];
        alu_v2_d         = v2_q[iss_idx];
        alu_rob_id_d     = rob_q[iss_idx];
        busy_d[iss_idx]  = 1'b0;
      end

      // free_found is exactly !rs_full; the slot is never the one being issued.
      if (disp_valid && free_found) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = disp_op;
        rob_d[free_idx]  = disp_rob_id;
        q1_d[free_idx]   = disp_q1;
        q2_d[free_idx]   = disp_q2;
        if (disp_q1_rdy) begin
          v1_d[free_idx] = disp_v1;
          r1_d[free_idx] = 1'b1;
        end else if (alu_hit(disp_q1)) begin
          v1_d[free_idx] = alu_cdb_value;
          r1_d[free_idx] = 1'b1;
        end else if (lsb_hit(disp_q1)) begin
          v1_d[free_idx] = lsb_cdb_value;
          r1_d[free_idx] = 1'b1;
        end else begin
          v1_d[free_idx] = disp_v1;
          r1_d[free_idx] = 1'b0;
        end
        if (disp_q2_rdy) begin
          v2_d[free_idx] = disp_v2;
          r2_d[free_idx] = 1'b1;
        end else if (alu_hit(disp_q2)) begin
          v2_d[free_idx] = alu_cdb_value;
          r2_d[free_idx] = 1'b1;
        end else if (lsb_hit(disp_q2)) begin
          v2_d[free_idx] = lsb_cdb_value;
          r2_d[free_idx] = 1'b1;
        end else begin
          v2_d[free_idx] = disp_v2;
          r2_d[free_idx] = 1'b0;
        end
      end
    end
  end

  // State register; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_d_reset: begin
        busy_q <= '0;
        r1_q   <= '0;
        r2_q   <= '0;
      end
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
      end
      alu_valid_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_v1_q     <= '0;
      alu_v2_q     <= '0;
      alu_rob_id_q <= '0;
    end else if (rdy) begin
      busy_q       <= busy_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      op_q         <= op_d;
      rob_q        <= rob_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      alu_valid_q  <= alu_valid_d;
      alu_op_q     <= alu_op_d;
      alu_v1_q     <= alu_v1_d;
      alu_v2_q     <= alu_v2_d;
      alu_rob_id_q <= alu_rob_id_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        disp_valid;
  logic [4:0]  disp_op;
  logic [3:0]  disp_rob_id;
  logic        disp_q1_rdy, disp_q2_rdy;
  logic [31:0] disp_v1, disp_v2;
  logic [3:0]  disp_q1, disp_q2;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        alu_valid;
  logic [4:0]  alu_op;
  logic [31:0] alu_v1, alu_v2;
  logic [3:0]  alu_rob_id;
  logic        rs_full;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reservation_station #(.RS_SIZE_WIDTH(3), .ROB_SIZE_WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .disp_valid     (disp_valid),
    .disp_op        (disp_op),
    .disp_rob_id    (disp_rob_id),
    .disp_q1_rdy    (disp_q1_rdy),
    .disp_v1        (disp_v1),
    .disp_q1        (disp_q1),
    .disp_q2_rdy    (disp_q2_rdy),
    .disp_v2        (disp_v2),
    .disp_q2        (disp_q2),
    .alu_cdb_valid  (alu_cdb_valid),
    .alu_cdb_rob_id (alu_cdb_rob_id),
    .alu_cdb_value  (alu_cdb_value),
    .lsb_cdb_valid  (lsb_cdb_valid),
    .lsb_cdb_rob_id (lsb_cdb_rob_id),
    .lsb_cdb_value  (lsb_cdb_value),
    .alu_valid      (alu_valid),
    .alu_op         (alu_op),
    .alu_v1         (alu_v1),
    .alu_v2         (alu_v2),
    .alu_rob_id     (alu_rob_id),
    .rs_full        (rs_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_issue(input string tag, input logic [4:0] op, input logic [3:0] rob,
                             input logic [31:0] v1, input logic [31:0] v2);
    check({tag, "_valid"}, 32'(alu_valid), 32'd1);
    check({tag, "_op"},    32'(alu_op), 32'(op));
    check({tag, "_rob"},   32'(alu_rob_id), 32'(rob));
    check({tag, "_v1"},    alu_v1, v1);
    check({tag, "_v2"},    alu_v2, v2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid    = 1'b0;
    alu_cdb_valid = 1'b0;
    lsb_cdb_valid = 1'b0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [3:0] rob,
                      input logic r1, input logic [31:0] v1, input logic [3:0] q1,
                      input logic r2, input logic [31:0] v2, input logic [3:0] q2);
    disp_valid  = 1'b1;
    disp_op     = op;
    disp_rob_id = rob;
    disp_q1_rdy = r1;
    disp_v1     = v1;
    disp_q1     = q1;
    disp_q2_rdy = r2;
    disp_v2     = v2;
    disp_q2     = q2;
  endtask

  task automatic alu_cdb(input logic [3:0] t, input logic [31:0] v);
    alu_cdb_valid  = 1'b1;
    alu_cdb_rob_id = t;
    alu_cdb_value  = v;
  endtask

  task automatic lsb_cdb(input logic [3:0] t, input logic [31:0] v);
    lsb_cdb_valid  = 1'b1;
    lsb_cdb_rob_id = t;
    lsb_cdb_value  = v;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    disp(5'd0, 4'd0, 1'b0, '0, 4'd0, 1'b0, '0, 4'd0);
    alu_cdb(4'd0, '0);
    lsb_cdb(4'd0, '0);
    idle();
    tick(); tick();

    // Reset state
    check("rst_valid", 32'(alu_valid), 32'd0);
    check("rst_op",    32'(alu_op), 32'd0);
    check("rst_v1",    alu_v1, 32'd0);
    check("rst_v2",    alu_v2, 32'd0);
    check("rst_rob",   32'(alu_rob_id), 32'd0);
    check("rst_full",  32'(rs_full), 32'd0);
    rst = 1'b0;

    // 1: both ready -> issue one edge after the dispatch edge
    disp(5'h00, 4'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    tick(); idle();
    check("t1_lat", 32'(alu_valid), 32'd0);
    tick();
    check_issue("t1", 5'h00, 4'd1, 32'd5, 32'd7);
    tick();
    check("t1_pulse", 32'(alu_valid), 32'd0);

    // 2: q1=3 waits for ALU CDB
    disp(5'h08, 4'd2, 1'b0, 32'd0, 4'd3, 1'b1, 32'd1, 4'd0);
    tick(); idle();
    tick();
    check("t2_wait", 32'(alu_valid), 32'd0);
    alu_cdb(4'd3, 32'h10);
    tick(); idle();
    check("t2_wake", 32'(alu_valid), 32'd0);
    tick();
    check_issue("t2", 5'h08, 4'd2, 32'h10, 32'd1);

    // 3: same-cycle LSB bypass on q2=6
    disp(5'h10, 4'd5, 1'b1, 32'd3, 4'd0, 1'b0, 32'd0, 4'd6);
    lsb_cdb(4'd6, 32'hFF);
    tick(); idle();
    check("t3_lat", 32'(alu_valid), 32'd0);
    tick();
    check_issue("t3", 5'h10, 4'd5, 32'd3, 32'hFF);

    // 4: fill all 8 entries, entry i waits on tag 8+i
    for (int i = 0; i < 8; i++) begin
      disp(5'(i), 4'(i), 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'h100 + 32'(i), 4'd0);
      tick();
    end
    idle();
    check("t4_full", 32'(rs_full), 32'd1);
    check("t4_noiss", 32'(alu_valid), 32'd0);
    disp(5'h1F, 4'd9, 1'b1, 32'hAA, 4'd0, 1'b1, 32'hBB, 4'd0);
    tick(); idle();
    check("t4_full9", 32'(rs_full), 32'd1);
    check("t4_ign9", 32'(alu_valid), 32'd0);
    alu_cdb(4'd10, 32'h22);
    tick(); idle();
    check("t4_wfull", 32'(rs_full), 32'd1);
    tick();
    check_issue("t4", 5'd2, 4'd2, 32'h22, 32'h102);
    check("t4_drop", 32'(rs_full), 32'd0);
    tick();
    check("t4_after", 32'(alu_valid), 32'd0);

    // 5: entries 1 and 4 woken together -> 1 then 4
    alu_cdb(4'd9, 32'h91);
    lsb_cdb(4'd12, 32'hC4);
    tick(); idle();
    check("t5_wake", 32'(alu_valid), 32'd0);
    tick();
    check_issue("t5a", 5'd1, 4'd1, 32'h91, 32'h101);
    tick();
    check_issue("t5b", 5'd4, 4'd4, 32'hC4, 32'h104);

    // 6: clear with 5 busy entries, first frozen by rdy=0
    rdy = 1'b0; clear = 1'b1;
    alu_cdb(4'd8, 32'h80);
    tick();
    check("t6_hold_v", 32'(alu_valid), 32'd1);
    check("t6_hold_r", 32'(alu_rob_id), 32'd4);
    tick();
    check("t6_hold_v2", 32'(alu_valid), 32'd1);
    rdy = 1'b1;
    tick();
    check("t6_clr_v", 32'(alu_valid), 32'd0);
    check("t6_clr_f", 32'(rs_full), 32'd0);
    clear = 1'b0;
    alu_cdb(4'd8, 32'h80);
    lsb_cdb(4'd11, 32'h83);
    tick(); idle();
    tick();
    check("t6_empty", 32'(alu_valid), 32'd0);
    tick();
    check("t6_empty2", 32'(alu_valid), 32'd0);

    // Async reset mid-operation drops a pending issue
    disp(5'h03, 4'd7, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    tick(); idle();
    rst = 1'b1;
    #1;
    check("rst_mid_v", 32'(alu_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_lost", 32'(alu_valid), 32'd0);
    check("rst_mid_rob", 32'(alu_rob_id), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
